fifo_drain_arbiter: RTL and testbench
=====================================

Name: fifo_drain_arbiter

Overview:
- Round-robin scheduler that drains NCH sensor-channel FIFOs into one shared output stream, tagging each word with its source channel and overflow status.
- Sits between the per-channel sensor FIFOs (first-word fall-through: dout valid whenever not empty; rd pops) and the single downstream consumer (key-detect / packetiser).
- Generates each FIFO's rd strobe.
- Also keeps sticky per-channel overflow status for host readout.

Parameters:
- NCH, 4, number of channel FIFOs (2..16).
- LOGNCH, 2, width of channel index; must satisfy (1<<LOGNCH) >= NCH.
- WIDTH, 4, data width of each FIFO word.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ch_en  input  NCH  per-channel enable mask; disabled channels are never granted.
- fifo_empty  input  NCH  empty flag from each channel FIFO.
- fifo_ovf  input  NCH  overflow flag from each channel FIFO.
- fifo_dout  input  NCH*WIDTH  concatenated FIFO heads; channel i occupies bits [i*WIDTH +: WIDTH].
- fifo_rd  output  NCH  one-hot pop strobe, combinational, at most one bit high.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  WIDTH  captured FIFO word.
- out_chan  output  LOGNCH  source channel of out_data.
- out_ovf  output  1  source FIFO was in overflow when the word was popped; the word is suspect.
- ovf_sticky  output  NCH  per-channel sticky overflow status.
- ovf_clr  input  NCH  write-1-to-clear for ovf_sticky.

Behaviour:
- **Reset.** The following go to 0 asynchronously:
  - out_valid, out_data, out_chan, out_ovf, ovf_sticky;
  - rr_ptr (internal, LOGNCH bits).
  - While reset is high, fifo_rd is forced to 0.
- **Request.** req[i] = ch_en[i] & (~fifo_empty[i] | fifo_ovf[i]). An overflowed channel is drained even when empty reads true, because the FIFO pointers have wrapped.
- **Load condition.** load = |req & (~out_valid | out_ready). The output stage is a single register that allows back-to-back transfers.
- **Grant.** grant is the first requesting channel found scanning upward from rr_ptr, wrapping modulo NCH. Grant is one-hot and combinational; fifo_rd = load ? grant : 0.
- **On a clock edge with load:**
  - out_data <= fifo_dout[g];
  - out_chan <= g;
  - out_ovf <= fifo_ovf[g];
  - out_valid <= 1;
  - rr_ptr <= (g == NCH-1) ? 0 : g+1.
- **On a clock edge with out_valid & out_ready & ~load:** out_valid <= 0. out_data, out_chan and out_ovf hold their last values.
- **Latency.** A word at a FIFO head with the output idle appears on out_valid on the next edge, i.e. 1 cycle.
- **Throughput.** With out_ready tied high, one word per cycle sustained.
- **States.** The block has exactly two states, encoded by out_valid:
  - EMPTY -> FULL on load.
  - FULL -> FULL on handshake with load.
  - FULL -> EMPTY on handshake without load.
  - FULL holds on !out_ready, with fifo_rd = 0.
- **Stall.** While out_valid && !out_ready:
  - out_* are stable;
  - no pops occur;
  - rr_ptr is unchanged.
- **Fairness.** With k channels continuously requesting, each is granted exactly once per k grants.
- **rr_ptr vs. disabled channels.** rr_ptr may point at a disabled or empty channel; the scan simply skips it.
- **ch_en cleared while a word is held.** The held word is still delivered.
- **ovf_sticky.** On every edge, ovf_sticky <= (ovf_sticky & ~ovf_clr) | fifo_ovf. This is independent of ch_en. If set and clear hit the same bit in the same cycle, set wins.
- **NCH not a power of two.** Channel indices >= NCH never appear on out_chan.
- **Reset mid-transfer.** The held word is discarded and no pop is issued. After reset release, the first grant starts from channel 0.

Optional Feature:
- Macro: FIFO_ARB_PRIO0_EN.
- **Defined:** channel 0 has strict priority.
  - If req[0], then g = 0 regardless of rr_ptr, and rr_ptr is not updated.
  - Otherwise the round-robin scan covers channels 1..NCH-1 only.
- **Undefined:** pure round-robin over all channels as described above. This is the default build.

Test Plan:
- **Single pop.** Reset, then ch 2 non-empty with head 4'hA, out_ready=1 → fifo_rd=4'b0100 for 1 cycle; next cycle out_valid=1, out_data=A, out_chan=2, out_ovf=0.
- **Round-robin, all requesting.** All 4 channels non-empty, out_ready=1 → out_chan sequence 0,1,2,3,0,1 and one pop per cycle.
- **Backpressure.** out_ready=0 for 5 cycles with all channels requesting → fifo_rd=0 throughout; out_data/out_chan stable; rr_ptr frozen. Raise out_ready → the next grant is the channel after the held one.
- **Overflow.** ch 1 with empty=1 and ovf=1 → granted; out_ovf=1 and ovf_sticky[1]=1. Then ovf_clr=4'b0010 while fifo_ovf[1]=1 → sticky stays 1. Pulse ovf_clr again once fifo_ovf[1]=0 → sticky clears.
- **Enable mask and async reset.** ch_en=4'b1010 with all non-empty → only channels 1 and 3 alternate. Assert reset asynchronously mid-stall (between edges) → out_valid drops immediately and fifo_rd=0.
- **FIFO_ARB_PRIO0_EN defined.** ch 0 and ch 3 continuously requesting → out_chan is always 0. Drop ch 0 → ch 3 is granted on the next cycle.

Source files
------------

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NCH channel FIFOs into one tagged output stream.
// Optional FIFO_ARB_PRIO0_EN: channel 0 gets strict priority over the others.
module fifo_drain_arbiter #(
    parameter int NCH    = 4,
    parameter int LOGNCH = 2,
    parameter int WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH-1:0]       fifo_empty,
    input  logic [NCH-1:0]       fifo_ovf,
    input  logic [NCH*WIDTH-1:0] fifo_dout,
    output logic [NCH-1:0]       fifo_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [LOGNCH-1:0]    out_chan,
    output logic                 out_ovf,
    output logic [NCH-1:0]       ovf_sticky,
    input  logic [NCH-1:0]       ovf_clr
);

`ifdef FIFO_ARB_PRIO0_EN
    localparam logic PRIO0 = 1'b1;
`else
    localparam logic PRIO0 = 1'b0;
`endif

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    logic [LOGNCH-1:0]   rr_ptr;
    logic [NCH-1:0]      req;
    logic [NCH-1:0]      grant;
    logic [LOGNCH-1:0]   g;
    logic [LOGNCH-1:0]   idx;
    logic [LOGNCH-1:0]   next_ptr;
    logic                found;
    logic                load;
    int                  s;

    // An overflowed FIFO has wrapped pointers, so drain it even if empty.
    assign req       = ch_en & (~fifo_empty | fifo_ovf);
    assign out_valid = (state == FULL);
    assign load      = (|req) & (~out_valid | out_ready);
    assign fifo_rd   = (load && !reset) ? grant : '0;
    assign next_ptr  = (g == LOGNCH'(NCH - 1)) ? '0 : g + 1'b1;

    always_comb begin
        grant = '0;
        g     = '0;
        found = 1'b0;
        s     = 0;
        idx   = '0;
        if (PRIO0 && req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
        for (int k = 0; k < NCH; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NCH)
                s = s - NCH;
            idx = s[LOGNCH-1:0];
            if (!found && req[idx] && (!PRIO0 || idx != '0)) begin
                grant[idx] = 1'b1;
                g          = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_chan   <= '0;
            out_ovf    <= 1'b0;
            rr_ptr     <= '0;
            ovf_sticky <= '0;
        end else begin
            // Set wins over a simultaneous clear.
            ovf_sticky <= (ovf_sticky & ~ovf_clr) | fifo_ovf;
            if (load) begin
                out_data <= fifo_dout[int'(g)*WIDTH +: WIDTH];
                out_chan <= g;
                out_ovf  <= fifo_ovf[g];
                if (!(PRIO0 && req[0]))
                    rr_ptr <= next_ptr;
            end
            case (state)
                EMPTY: if (load) state <= FULL;
                FULL:  if (out_ready && !load) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter; channel heads are counters.
// Define FIFO_ARB_PRIO0_EN to also run the channel-0 priority scenario.
module tb_fifo_drain_arbiter;

    localparam int NCH    = 4;
    localparam int LOGNCH = 2;
    localparam int WIDTH  = 4;

    typedef struct packed {
        logic [WIDTH-1:0]  data;
        logic [LOGNCH-1:0] chan;
        logic              ovf;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       ch_en;
    logic [NCH-1:0]       fifo_empty;
    logic [NCH-1:0]       fifo_ovf;
    logic [NCH*WIDTH-1:0] fifo_dout;
    logic [NCH-1:0]       fifo_rd;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [LOGNCH-1:0]    out_chan;
    logic                 out_ovf;
    logic [NCH-1:0]       ovf_sticky;
    logic [NCH-1:0]       ovf_clr;

    int   asserts  = 0;
    int   failures = 0;
    int   pops     = 0;
    int   cnt  [NCH];
    int   ecnt [NCH];
    exp_t sb [$];

    fifo_drain_arbiter #(
        .NCH(NCH), .LOGNCH(LOGNCH), .WIDTH(WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .ch_en(ch_en),
        .fifo_empty(fifo_empty), .fifo_ovf(fifo_ovf),
        .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] head(int c, int n);
        return WIDTH'(c * 5 + n);
    endfunction

    task automatic update_dout();
        for (int i = 0; i < NCH; i++)
            fifo_dout[i*WIDTH +: WIDTH] = head(i, cnt[i]);
    endtask

    task automatic expect_word(int c, logic ovf);
        exp_t e;
        e.data = head(c, ecnt[c]);
        e.chan = LOGNCH'(c);
        e.ovf  = ovf;
        ecnt[c]++;
        sb.push_back(e);
    endtask

    // One clock: check the handshake before the edge, apply pops after it.
    task automatic cycle();
        logic [NCH-1:0] rd;
        exp_t e;
        #1;
        rd = fifo_rd;
        asserts++;
        if ($countones(rd) > 1) begin
            failures++;
            $display("FAIL onehot: fifo_rd=%b, required at most one bit", rd);
        end
        if (out_valid && out_ready) begin
            asserts++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: data=%h chan=%0d, none expected",
                         out_data, out_chan);
            end else begin
                e = sb.pop_front();
                if ({out_data, out_chan, out_ovf} !== e) begin
                    failures++;
                    $display("FAIL word: got d=%h c=%0d o=%b, required d=%h c=%0d o=%b",
                             out_data, out_chan, out_ovf, e.data, e.chan, e.ovf);
                end
            end
        end
        if (rd != '0) pops++;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
            if (rd[i]) cnt[i]++;
        update_dout();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic check_drained(string name);
        asserts++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drained: %0d words outstanding, required 0",
                     name, sb.size());
        end
    endtask

    task automatic test_reset();
        ch_en = '1;
        fifo_empty = '0;
        reset = 1'b1;
        #1;
        asserts++;
        if ({out_valid, out_data, out_chan, out_ovf, ovf_sticky, fifo_rd} !== '0) begin
            failures++;
            $display("FAIL reset_state: v=%b d=%h c=%0d o=%b s=%b rd=%b, required all 0",
                     out_valid, out_data, out_chan, out_ovf, ovf_sticky, fifo_rd);
        end
        @(negedge clk);
        fifo_empty = '1;
        do_reset();
    endtask

    task automatic test_single_pop();
        ch_en = '1;
        out_ready = 1'b1;
        fifo_empty = 4'b1011;
        #1;
        asserts++;
        if (fifo_rd !== 4'b0100) begin
            failures++;
            $display("FAIL single_rd: fifo_rd=%b, required 0100", fifo_rd);
        end
        asserts++;
        if (head(2, cnt[2]) !== 4'hA) begin
            failures++;
            $display("FAIL single_head: head=%h, required a", head(2, cnt[2]));
        end
        expect_word(2, 1'b0);
        cycle();
        fifo_empty = '1;
        #1;
        asserts++;
        if ({out_valid, out_data, out_chan, out_ovf, fifo_rd} !== {1'b1, 4'hA, 2'd2, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL single_out: v=%b d=%h c=%0d o=%b rd=%b, required 1 a 2 0 0000",
                     out_valid, out_data, out_chan, out_ovf, fifo_rd);
        end
        cycle();
        check_drained("single");
    endtask

    task automatic test_round_robin();
        int p0;
        do_reset();
        ch_en = '1;
        out_ready = 1'b1;
        fifo_empty = '0;
        p0 = pops;
        for (int i = 0; i < 6; i++) begin
            expect_word(i % NCH, 1'b0);
            cycle();
        end
        asserts++;
        if (pops - p0 != 6) begin
            failures++;
            $display("FAIL rr_pops: %0d pop cycles, required 6", pops - p0);
        end
        fifo_empty = '1;
        cycle();
        check_drained("rr");
    endtask

    task automatic test_backpressure();
        do_reset();
        ch_en = '1;
        out_ready = 1'b1;
        fifo_empty = '0;
        expect_word(0, 1'b0);
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            asserts++;
            if ({fifo_rd, out_valid, out_data, out_chan} !== {4'b0000, 1'b1, sb[0].data, sb[0].chan}) begin
                failures++;
                $display("FAIL stall: rd=%b v=%b d=%h c=%0d, required 0000 1 %h %0d",
                         fifo_rd, out_valid, out_data, out_chan, sb[0].data, sb[0].chan);
            end
            cycle();
        end
        out_ready = 1'b1;
        expect_word(1, 1'b0);
        cycle();
        fifo_empty = '1;
        cycle();
        check_drained("bp");
    endtask

    task automatic test_overflow();
        do_reset();
        ch_en = '1;
        out_ready = 1'b1;
        fifo_empty = '1;
        fifo_ovf = 4'b0010;
        expect_word(1, 1'b1);
        cycle();
        asserts++;
        if (ovf_sticky !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_set: ovf_sticky=%b, required 0010", ovf_sticky);
        end
        ovf_clr = 4'b0010;
        expect_word(1, 1'b1);
        cycle();
        asserts++;
        if (ovf_sticky !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_set_wins: ovf_sticky=%b, required 0010", ovf_sticky);
        end
        fifo_ovf = '0;
        ovf_clr = '0;
        cycle();
        asserts++;
        if (ovf_sticky !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_hold: ovf_sticky=%b, required 0010", ovf_sticky);
        end
        ovf_clr = 4'b0010;
        cycle();
        ovf_clr = '0;
        asserts++;
        if (ovf_sticky !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_clear: ovf_sticky=%b, required 0000", ovf_sticky);
        end
        check_drained("ovf");
    endtask

    task automatic test_mask_and_reset();
        do_reset();
        ch_en = 4'b1010;
        out_ready = 1'b1;
        fifo_empty = '0;
        for (int i = 0; i < 4; i++) begin
            expect_word((i % 2 == 0) ? 1 : 3, 1'b0);
            cycle();
        end
        out_ready = 1'b0;
        cycle();
        cycle();
        asserts++;
        if (sb.size() != 1) begin
            failures++;
            $display("FAIL mask_held: %0d words outstanding, required 1", sb.size());
        end
        #2;
        reset = 1'b1;
        #1;
        asserts++;
        if ({out_valid, fifo_rd} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: v=%b rd=%b, required 0 0000", out_valid, fifo_rd);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        ch_en = '1;
        out_ready = 1'b1;
        expect_word(0, 1'b0);
        cycle();
        fifo_empty = '1;
        cycle();
        check_drained("mask");
    endtask

`ifdef FIFO_ARB_PRIO0_EN
    task automatic test_prio0();
        do_reset();
        ch_en = 4'b1001;
        out_ready = 1'b1;
        fifo_empty = '0;
        for (int i = 0; i < 4; i++) begin
            expect_word(0, 1'b0);
            cycle();
        end
        ch_en = 4'b1000;
        expect_word(3, 1'b0);
        cycle();
        fifo_empty = '1;
        cycle();
        check_drained("prio0");
    endtask
`endif

    initial begin
        for (int i = 0; i < NCH; i++) begin
            cnt[i] = 0;
            ecnt[i] = 0;
        end
        reset = 1'b1;
        ch_en = '0;
        fifo_empty = '1;
        fifo_ovf = '0;
        ovf_clr = '0;
        out_ready = 1'b0;
        update_dout();
        @(negedge clk);
        test_reset();
        test_single_pop();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_mask_and_reset();
`ifdef FIFO_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, failures);
        $finish;
    end

endmodule
